// File: rtl/itch_beat_parser_pkg.sv
// itch_pkg: ITCH message type codes, type bytes, message lengths and the decoded record format
package itch_pkg;
   typedef enum logic [3:0] {
      MSG_NONE    = 4'd0,
      MSG_ADD     = 4'd1,
      MSG_DELETE  = 4'd2,
      MSG_CANCEL  = 4'd3,
      MSG_EXECUTE = 4'd4
   } msg_type_e;
   localparam logic [7:0] TB_ADD = 8'h41;
   localparam logic [7:0] TB_DEL = 8'h44;
   localparam logic [7:0] TB_EXE = 8'h45;
   localparam logic [7:0] TB_CXL = 8'h58;
   localparam logic [5:0] LEN_ADD = 6'd18;
   localparam logic [5:0] LEN_DEL = 6'd9;
   localparam logic [5:0] LEN_CXL = 6'd13;
   localparam logic [5:0] LEN_EXE = 6'd13;
   typedef struct packed {
      msg_type_e     typ;
      logic [63:0]   order_ref;
      logic          side;
      logic [31:0]   shares;
      logic [31:0]   price;
   } rec_t;
   function automatic msg_type_e decode_type(input logic [7:0] b);
      return b == TB_ADD ? MSG_ADD : b == TB_DEL ? MSG_DELETE :
             b == TB_CXL ? MSG_CANCEL : b == TB_EXE ? MSG_EXECUTE : MSG_NONE;
   endfunction
   function automatic logic [5:0] msg_len(input msg_type_e t);
      return t == MSG_ADD ? LEN_ADD : t == MSG_DELETE ? LEN_DEL :
             t == MSG_CANCEL ? LEN_CXL : t == MSG_EXECUTE ? LEN_EXE : 6'd0;
   endfunction
endpackage

// File: rtl/itch_beat_parser_if.sv
// itch_axis_if / itch_rec_if: ITCH byte stream (tdata/tkeep/tlast/tvalid/tready)
// and decoded record port (valid/ready plus record fields)
interface itch_axis_if #(parameter int BYTES_PER_BEAT = 4);
   logic [8*BYTES_PER_BEAT-1:0] s00_axis_tdata;
   logic [BYTES_PER_BEAT-1:0]   s00_axis_tkeep;
   logic                        s00_axis_tlast;
   logic                        s00_axis_tvalid;
   logic                        s00_axis_tready;
   modport master (output s00_axis_tdata, s00_axis_tkeep, s00_axis_tlast, s00_axis_tvalid,
                   input  s00_axis_tready);
   modport slave  (input  s00_axis_tdata, s00_axis_tkeep, s00_axis_tlast, s00_axis_tvalid,
                   output s00_axis_tready);
endinterface

interface itch_rec_if;
   import itch_pkg::*;
   logic        m_rec_valid;
   logic        m_rec_ready;
   logic [3:0]  m_rec_type;
   logic [63:0] m_rec_order_ref;
   logic        m_rec_side;
   logic [31:0] m_rec_shares;
   logic [31:0] m_rec_price;
   modport master (output m_rec_valid, m_rec_type, m_rec_order_ref, m_rec_side, m_rec_shares,
                          m_rec_price,
                   input  m_rec_ready);
   modport slave  (input  m_rec_valid, m_rec_type, m_rec_order_ref, m_rec_side, m_rec_shares,
                          m_rec_price,
                   output m_rec_ready);
endinterface

// File: rtl/itch_beat_parser_rec_fifo.sv
// itch_rec_fifo: first-word fall-through FIFO of rec_t
// Ports: clk, rst_n (async low), push/din, pop/dout (zero when empty), full, empty, count
module itch_rec_fifo
   import itch_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  rec_t                     din,
   input  logic                     pop,
   output rec_t                     dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   rec_t          mem_q [DEPTH];
   logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [AW:0]   cnt_q, cnt_d;
   logic          do_pop;
   always_comb begin
      empty  = cnt_q == '0;
      full   = cnt_q == (AW+1)'(DEPTH);
      do_pop = pop & ~empty;
      wr_d   = push ? wr_q + AW'(1) : wr_q;
      rd_d   = do_pop ? rd_q + AW'(1) : rd_q;
      cnt_d  = cnt_q + (AW+1)'(push) - (AW+1)'(do_pop);
      dout   = empty ? '0 : mem_q[rd_q];
      count  = cnt_q;
   end
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_q] <= din;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end
endmodule

// File: rtl/itch_beat_parser.sv
// itch_beat_parser: multi-byte-per-beat ITCH parser decoding Add/Delete/Cancel/Execute into records
// Ports: s00_axis_aclk, s00_axis_aresetn (async low), s_axis (stream in), m_rec (record out),
//        stat_msg_count / stat_err_count (wrapping), err_pulse (one cycle per dropped packet)
module itch_beat_parser
   import itch_pkg::*;
#(
   parameter int BYTES_PER_BEAT = 4,
   parameter int FIFO_DEPTH     = 4
) (
   input  logic         s00_axis_aclk,
   input  logic         s00_axis_aresetn,
   itch_axis_if.slave   s_axis,
   itch_rec_if.master   m_rec,
   output logic [31:0]  stat_msg_count,
   output logic [31:0]  stat_err_count,
   output logic         err_pulse
);
   localparam int B  = BYTES_PER_BEAT;
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [1:0] S_IDLE = 2'd0, S_BODY = 2'd1, S_DROP = 2'd2;
   logic [1:0]    state_q, state_d;
   logic [4:0]    byte_cnt_q, byte_cnt_d;
   rec_t          rec_q, rec_d, rec_nxt, fifo_dout;
   logic [31:0]   msg_cnt_q, msg_cnt_d, err_cnt_q, err_cnt_d;
   logic          err_pulse_q, err_pulse_d;
   logic          accept, idle, last, contig, err, push, fifo_full, fifo_empty;
   msg_type_e     typ;
   logic [5:0]    len, base, total, off;
   logic [3:0]    nb;
   logic [7:0]    lane_b;
   logic [CW-1:0] fifo_count;
   assign s_axis.s00_axis_tready = s00_axis_aresetn & (fifo_count != CW'(FIFO_DEPTH));
   always_comb begin
      accept = s_axis.s00_axis_tvalid & s_axis.s00_axis_tready;
      last   = s_axis.s00_axis_tlast;
      idle   = state_q == S_IDLE;
      // the type byte lives in lane 0 of the first beat; afterwards it is held in the accumulator
      typ    = idle ? (s_axis.s00_axis_tkeep[0] ? decode_type(s_axis.s00_axis_tdata[7:0]) : MSG_NONE)
                    : rec_q.typ;
      len    = msg_len(typ);
      base   = idle ? 6'd0 : {1'b0, byte_cnt_q};
      nb     = '0;
      for (int i = 0; i < B; i++) nb = nb + 4'(s_axis.s00_axis_tkeep[i]);
      total  = base + 6'(nb);
      // tkeep & (tkeep+1) is zero only for a ones-prefix (including all-zero)
      contig = (s_axis.s00_axis_tkeep & (s_axis.s00_axis_tkeep + B'(1))) == '0;
      err    = (typ == MSG_NONE) | (last ? ~contig : ~&s_axis.s00_axis_tkeep) |
               (total > len) | (last & (total < len));
      rec_nxt     = idle ? '0 : rec_q;
      rec_nxt.typ = typ;
      off         = '0;
      lane_b      = '0;
      for (int i = 0; i < B; i++) begin
         off    = base + 6'(i);
         lane_b = s_axis.s00_axis_tdata[8*i +: 8];
         if (s_axis.s00_axis_tkeep[i] && off != '0 && off < len) begin
            // big-endian: the earliest byte of each field lands in its MSB
            if (off <= 6'd8)
               rec_nxt.order_ref = rec_nxt.order_ref | (64'(lane_b) << {3'(6'd8 - off), 3'b000});
            else if (typ != MSG_ADD)
               rec_nxt.shares = rec_nxt.shares | (32'(lane_b) << {2'(6'd12 - off), 3'b000});
            else if (off == 6'd9)
               rec_nxt.side = lane_b == 8'h42;
            else if (off <= 6'd13)
               rec_nxt.shares = rec_nxt.shares | (32'(lane_b) << {2'(6'd13 - off), 3'b000});
            else
               rec_nxt.price = rec_nxt.price | (32'(lane_b) << {2'(6'd17 - off), 3'b000});
         end
      end
      push        = accept & (state_q != S_DROP) & last & ~err & ~fifo_full;
      state_d     = state_q;
      byte_cnt_d  = byte_cnt_q;
      rec_d       = rec_q;
      err_pulse_d = 1'b0;
      err_cnt_d   = err_cnt_q;
      msg_cnt_d   = msg_cnt_q + 32'(push);
      if (accept) begin
         if (state_q == S_DROP) begin
            state_d = last ? S_IDLE : S_DROP;
         end else if (err) begin
            state_d     = last ? S_IDLE : S_DROP;
            err_pulse_d = 1'b1;
            err_cnt_d   = err_cnt_q + 32'd1;
         end else if (last) begin
            state_d = S_IDLE;
         end else begin
            state_d    = S_BODY;
            byte_cnt_d = 5'(total);
            rec_d      = rec_nxt;
         end
      end
   end
   always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
      if (!s00_axis_aresetn) begin
         state_q     <= S_IDLE;
         byte_cnt_q  <= '0;
         rec_q       <= '0;
         msg_cnt_q   <= '0;
         err_cnt_q   <= '0;
         err_pulse_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         byte_cnt_q  <= byte_cnt_d;
         rec_q       <= rec_d;
         msg_cnt_q   <= msg_cnt_d;
         err_cnt_q   <= err_cnt_d;
         err_pulse_q <= err_pulse_d;
      end
   end
   itch_rec_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (s00_axis_aclk),
      .rst_n (s00_axis_aresetn),
      .push  (push),
      .din   (rec_nxt),
      .pop   (m_rec.m_rec_ready),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );
   assign m_rec.m_rec_valid     = ~fifo_empty;
   assign m_rec.m_rec_type      = fifo_dout.typ;
   assign m_rec.m_rec_order_ref = fifo_dout.order_ref;
   assign m_rec.m_rec_side      = fifo_dout.side;
   assign m_rec.m_rec_shares    = fifo_dout.shares;
   assign m_rec.m_rec_price     = fifo_dout.price;
   assign stat_msg_count        = msg_cnt_q;
   assign stat_err_count        = err_cnt_q;
   assign err_pulse             = err_pulse_q;
endmodule

// File: tb/tb_itch_beat_parser.sv
// tb_itch_beat_parser: scoreboard bench for 4-byte and 1-byte beat parser instances
module tb_itch_beat_parser;
   import itch_pkg::*;
   typedef logic [7:0] bq_t[$];
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;
   itch_axis_if #(.BYTES_PER_BEAT(4)) ax4 ();
   itch_axis_if #(.BYTES_PER_BEAT(1)) ax1 ();
   itch_rec_if rc4 ();
   itch_rec_if rc1 ();
   logic [31:0] mc4, ec4, mc1, ec1;
   logic        ep4, ep1;
   logic        done5 = 1'b0;
   int          checks = 0, errors = 0;
   rec_t        exp4[$], exp1[$];

   itch_beat_parser #(.BYTES_PER_BEAT(4), .FIFO_DEPTH(4)) dut4 (
      .s00_axis_aclk(clk), .s00_axis_aresetn(rst_n), .s_axis(ax4), .m_rec(rc4),
      .stat_msg_count(mc4), .stat_err_count(ec4), .err_pulse(ep4));
   itch_beat_parser #(.BYTES_PER_BEAT(1), .FIFO_DEPTH(4)) dut1 (
      .s00_axis_aclk(clk), .s00_axis_aresetn(rst_n), .s_axis(ax1), .m_rec(rc1),
      .stat_msg_count(mc1), .stat_err_count(ec1), .err_pulse(ep1));

   task automatic chk(input string nm, input logic [135:0] act, input logic [135:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%0h expected=%0h", nm, act, exp);
      end
   endtask

   function automatic rec_t er(msg_type_e t, logic [63:0] r, logic s, logic [31:0] sh, logic [31:0] px);
      rec_t x;
      x.typ = t; x.order_ref = r; x.side = s; x.shares = sh; x.price = px;
      return x;
   endfunction

   function automatic bq_t mk_d(logic [63:0] r);
      bq_t q;
      q.push_back(8'h44);
      for (int i = 0; i < 8; i++) q.push_back(r[8*(7-i) +: 8]);
      return q;
   endfunction

   function automatic bq_t mk_xe(logic [7:0] t, logic [63:0] r, logic [31:0] sh);
      bq_t q;
      q.push_back(t);
      for (int i = 0; i < 8; i++) q.push_back(r[8*(7-i) +: 8]);
      for (int i = 0; i < 4; i++) q.push_back(sh[8*(3-i) +: 8]);
      return q;
   endfunction

   function automatic bq_t mk_a(logic [63:0] r, logic [7:0] s, logic [31:0] sh, logic [31:0] px);
      bq_t q;
      q.push_back(8'h41);
      for (int i = 0; i < 8; i++) q.push_back(r[8*(7-i) +: 8]);
      q.push_back(s);
      for (int i = 0; i < 4; i++) q.push_back(sh[8*(3-i) +: 8]);
      for (int i = 0; i < 4; i++) q.push_back(px[8*(3-i) +: 8]);
      return q;
   endfunction

   // present one beat, wait (bounded) until accepted, return #1 after the accepting edge
   task automatic beat(input int d, input logic [31:0] data, input logic [3:0] keep, input logic lst);
      int t = 0;
      if (d == 4) begin
         ax4.s00_axis_tdata = data; ax4.s00_axis_tkeep = keep;
         ax4.s00_axis_tlast = lst;  ax4.s00_axis_tvalid = 1'b1;
      end else begin
         ax1.s00_axis_tdata = data[7:0]; ax1.s00_axis_tkeep = keep[0];
         ax1.s00_axis_tlast = lst;       ax1.s00_axis_tvalid = 1'b1;
      end
      @(negedge clk);
      while (!(d == 4 ? ax4.s00_axis_tready : ax1.s00_axis_tready) && t < 300) begin
         t++;
         @(negedge clk);
      end
      if (t >= 300) begin
         checks++;
         errors++;
         $display("FAIL tready_timeout dut=%0d waited=%0d cycles, required <300", d, t);
      end
      @(posedge clk);
      #1;
      if (d == 4) ax4.s00_axis_tvalid = 1'b0;
      else ax1.s00_axis_tvalid = 1'b0;
   endtask

   // split a message into beats; xk is ORed into the last beat's keep to corrupt it
   task automatic send(input int d, input bq_t m, input logic [3:0] xk);
      logic [31:0] w;
      logic [3:0]  k;
      for (int i = 0; i < m.size(); i += d) begin
         w = '0;
         k = '0;
         for (int j = 0; j < d && i + j < m.size(); j++) begin
            w[8*j +: 8] = m[i+j];
            k[j] = 1'b1;
         end
         beat(d, w, (i + d >= m.size()) ? (k | xk) : k, i + d >= m.size());
      end
   endtask

   always @(negedge clk) begin
      if (rc4.m_rec_valid && rc4.m_rec_ready) begin
         if (exp4.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rec4_unexpected got type=%0d ref=%0h, required no record",
                     rc4.m_rec_type, rc4.m_rec_order_ref);
         end else
            chk("rec4", {rc4.m_rec_type, rc4.m_rec_order_ref, rc4.m_rec_side, rc4.m_rec_shares,
                         rc4.m_rec_price}, exp4.pop_front());
      end
      if (rc1.m_rec_valid && rc1.m_rec_ready) begin
         if (exp1.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rec1_unexpected got type=%0d ref=%0h, required no record",
                     rc1.m_rec_type, rc1.m_rec_order_ref);
         end else
            chk("rec1", {rc1.m_rec_type, rc1.m_rec_order_ref, rc1.m_rec_side, rc1.m_rec_shares,
                         rc1.m_rec_price}, exp1.pop_front());
      end
   end

   initial begin
      bq_t q;
      int  t;
      ax4.s00_axis_tdata = '0; ax4.s00_axis_tkeep = '0; ax4.s00_axis_tlast = 1'b0; ax4.s00_axis_tvalid = 1'b0;
      ax1.s00_axis_tdata = '0; ax1.s00_axis_tkeep = '0; ax1.s00_axis_tlast = 1'b0; ax1.s00_axis_tvalid = 1'b0;
      rc4.m_rec_ready = 1'b1;
      rc1.m_rec_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("tready_in_reset", ax4.s00_axis_tready, 0);
      chk("valid_rst", rc4.m_rec_valid, 0);
      chk("fields_rst", {rc4.m_rec_type, rc4.m_rec_order_ref, rc4.m_rec_side, rc4.m_rec_shares,
                         rc4.m_rec_price}, 0);
      chk("msgcnt_rst", mc4, 0);
      chk("errcnt_rst", ec4, 0);
      chk("errpulse_rst", ep4, 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("tready_after_rst", ax4.s00_axis_tready, 1);
      @(posedge clk);
      #1;
      // single byte per beat Delete
      exp1.push_back(er(MSG_DELETE, 64'h0102030405060708, 1'b0, 0, 0));
      send(1, mk_d(64'h0102030405060708), 4'h0);
      chk("latency_valid1", rc1.m_rec_valid, 1);
      chk("msgcnt1", mc1, 1);
      // single byte per beat Delete closed by an empty tlast beat
      exp1.push_back(er(MSG_DELETE, 64'hCAFEF00D12345678, 1'b0, 0, 0));
      q = mk_d(64'hCAFEF00D12345678);
      foreach (q[i]) beat(1, {24'h0, q[i]}, 4'h1, 1'b0);
      beat(1, 32'h0, 4'h0, 1'b1);
      chk("msgcnt1_empty_last", mc1, 2);
      // Add over 5 beats, last keep 0011
      exp4.push_back(er(MSG_ADD, 64'h1122334455667788, 1'b1, 32'd100, 32'h00012345));
      send(4, mk_a(64'h1122334455667788, 8'h42, 32'd100, 32'h00012345), 4'h0);
      chk("latency_valid4", rc4.m_rec_valid, 1);
      chk("msgcnt_add", mc4, 1);
      // short Delete
      q = mk_d(64'h0102030405060708);
      void'(q.pop_back());
      send(4, q, 4'h0);
      chk("errpulse_short", ep4, 1);
      chk("errcnt_short", ec4, 1);
      @(posedge clk);
      #1;
      chk("errpulse_one_cycle", ep4, 0);
      chk("msgcnt_after_short", mc4, 1);
      // unknown type over 3 beats, then an immediate Delete
      beat(4, 32'h0302015A, 4'hF, 1'b0);
      chk("errpulse_unknown", ep4, 1);
      beat(4, 32'h07060504, 4'hF, 1'b0);
      chk("errpulse_once_per_pkt", ep4, 0);
      beat(4, 32'h0B0A0908, 4'hF, 1'b1);
      exp4.push_back(er(MSG_DELETE, 64'hA1A2A3A4A5A6A7A8, 1'b0, 0, 0));
      send(4, mk_d(64'hA1A2A3A4A5A6A7A8), 4'h0);
      chk("errcnt_unknown", ec4, 2);
      chk("msgcnt_after_unknown", mc4, 2);
      // long Delete (one extra byte)
      q = mk_d(64'h1111111111111111);
      q.push_back(8'hEE);
      send(4, q, 4'h0);
      chk("errcnt_long", ec4, 3);
      // non-contiguous keep on last beat
      send(4, mk_d(64'h2222222222222222), 4'b0100);
      chk("errcnt_noncontig", ec4, 4);
      // partial keep on a non-last beat, then drop until tlast
      beat(4, 32'h03020144, 4'b0111, 1'b0);
      chk("errpulse_partial", ep4, 1);
      beat(4, 32'h07060504, 4'hF, 1'b1);
      chk("errcnt_partial", ec4, 5);
      chk("msgcnt_after_errors", mc4, 2);
      // backpressure: five Cancels into a depth-4 FIFO
      rc4.m_rec_ready = 1'b0;
      fork
         begin
            for (int i = 0; i < 5; i++) begin
               exp4.push_back(er(MSG_CANCEL, 64'h100 + 64'(i), 1'b0, 32'(10*i + 1), 0));
               send(4, mk_xe(8'h58, 64'h100 + 64'(i), 32'(10*i + 1)), 4'h0);
            end
            done5 = 1'b1;
         end
      join_none
      repeat (60) @(posedge clk);
      #1;
      chk("tready_full", ax4.s00_axis_tready, 0);
      chk("msgcnt_full", mc4, 6);
      chk("valid_full", rc4.m_rec_valid, 1);
      chk("head_held", rc4.m_rec_order_ref, 64'h100);
      rc4.m_rec_ready = 1'b1;
      t = 0;
      while (!done5 && t < 200) begin
         t++;
         @(posedge clk);
      end
      #1;
      chk("bp_sender_done", done5, 1);
      repeat (6) @(posedge clk);
      #1;
      chk("msgcnt_drained", mc4, 7);
      chk("sb4_drained", exp4.size(), 0);
      // reset in the middle of an Add, then a clean Execute
      q = mk_a(64'h5555666677778888, 8'h53, 32'd9, 32'd10);
      beat(4, {q[3], q[2], q[1], q[0]}, 4'hF, 1'b0);
      beat(4, {q[7], q[6], q[5], q[4]}, 4'hF, 1'b0);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("tready_mid_rst", ax4.s00_axis_tready, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("errcnt_after_rst", ec4, 0);
      chk("msgcnt_after_rst", mc4, 0);
      @(posedge clk);
      #1;
      exp4.push_back(er(MSG_EXECUTE, 64'hDEADBEEF00C0FFEE, 1'b0, 32'd77, 0));
      send(4, mk_xe(8'h45, 64'hDEADBEEF00C0FFEE, 32'd77), 4'h0);
      chk("msgcnt_exe", mc4, 1);
      chk("errcnt_exe", ec4, 0);
      repeat (5) @(posedge clk);
      #1;
      chk("sb4_empty", exp4.size(), 0);
      chk("sb1_empty", exp1.size(), 0);
      chk("errcnt1", ec1, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
